mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory between the fetch path (port IF) and the

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the CPU fetch/load-store ports, the unified memory and
// mem_port_arbiter. The master side is the CPU plus memory; the slave side is the arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic              gnt_if;

   // load/store port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_done;
   logic              gnt_d;

   // shared result and status
   logic [DATA_W-1:0] rdata;
   logic              err;
   logic              busy;

   // memory side
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  mem_addr, mem_wr, mem_wdata, gnt_if, gnt_d, if_done, d_done,
             rdata, err, busy
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output mem_addr, mem_wr, mem_wdata, gnt_if, gnt_d, if_done, d_done,
             rdata, err, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified instruction/data memory between the fetch and load/store ports:
// one access at a time, MEM_LAT-cycle memory phase, then a one-cycle done pulse to the owner.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_LAT   = 2,
   parameter int DATA_PRIO = 1
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);
   localparam logic       PRIO_D   = (DATA_PRIO != 0);

   state_t            state_r, state_nxt;
   logic [3:0]        cnt_r, cnt_nxt;
   logic              last_d_r, last_d_nxt;   // last grant went to D
   logic              own_d_r, own_d_nxt;     // current access belongs to D
   logic              load_r, load_nxt;       // aligned load: capture rdata on completion
   logic              mis_r, mis_nxt;         // current access is misaligned

   logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt;
   logic              mem_wr_r, mem_wr_nxt;
   logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt;
   logic              gnt_if_r, gnt_if_nxt;
   logic              gnt_d_r, gnt_d_nxt;
   logic              if_done_r, if_done_nxt;
   logic              d_done_r, d_done_nxt;
   logic [DATA_W-1:0] rdata_r, rdata_nxt;
   logic              err_r, err_nxt;
   logic              busy_r, busy_nxt;

   logic              any_req;
   logic              pick_d;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we;
   logic              sel_mis;

   // Winner selection, only consumed in IDLE. Round-robin favours the port not granted last.
   assign any_req  = bus.if_req | bus.d_req;
   assign pick_d   = bus.d_req & (~bus.if_req | PRIO_D | ~last_d_r);
   assign sel_addr = pick_d ? bus.d_addr : bus.if_addr;
   assign sel_we   = pick_d & bus.d_we;
   assign sel_mis  = (sel_addr[1:0] != 2'b00);

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         last_d_r    <= 1'b1;
         own_d_r     <= 1'b0;
         load_r      <= 1'b0;
         mis_r       <= 1'b0;
         mem_addr_r  <= '0;
         mem_wr_r    <= 1'b0;
         mem_wdata_r <= '0;
         gnt_if_r    <= 1'b0;
         gnt_d_r     <= 1'b0;
         if_done_r   <= 1'b0;
         d_done_r    <= 1'b0;
         rdata_r     <= '0;
         err_r       <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_r     <= state_nxt;
         cnt_r       <= cnt_nxt;
         last_d_r    <= last_d_nxt;
         own_d_r     <= own_d_nxt;
         load_r      <= load_nxt;
         mis_r       <= mis_nxt;
         mem_addr_r  <= mem_addr_nxt;
         mem_wr_r    <= mem_wr_nxt;
         mem_wdata_r <= mem_wdata_nxt;
         gnt_if_r    <= gnt_if_nxt;
         gnt_d_r     <= gnt_d_nxt;
         if_done_r   <= if_done_nxt;
         d_done_r    <= d_done_nxt;
         rdata_r     <= rdata_nxt;
         err_r       <= err_nxt;
         busy_r      <= busy_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state_r;
      unique case (state_r)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  if (cnt_r == 4'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs and bookkeeping
   always_comb begin
      cnt_nxt       = cnt_r;
      last_d_nxt    = last_d_r;
      own_d_nxt     = own_d_r;
      load_nxt      = load_r;
      mis_nxt       = mis_r;
      mem_addr_nxt  = mem_addr_r;
      mem_wr_nxt    = mem_wr_r;
      mem_wdata_nxt = mem_wdata_r;
      gnt_if_nxt    = gnt_if_r;
      gnt_d_nxt     = gnt_d_r;
      if_done_nxt   = if_done_r;
      d_done_nxt    = d_done_r;
      rdata_nxt     = rdata_r;
      err_nxt       = err_r;
      busy_nxt      = (state_nxt != IDLE);

      unique case (state_r)
         IDLE: begin
            if (any_req) begin
               mem_addr_nxt = sel_addr;
               mem_wr_nxt   = sel_we & ~sel_mis;
               if (pick_d) mem_wdata_nxt = bus.d_wdata;
               gnt_d_nxt    = pick_d;
               gnt_if_nxt   = ~pick_d;
               last_d_nxt   = pick_d;
               own_d_nxt    = pick_d;
               load_nxt     = ~sel_we & ~sel_mis;
               mis_nxt      = sel_mis;
               cnt_nxt      = CNT_LOAD;
            end
         end
         ACCESS: begin
            if (cnt_r == 4'd0) begin
               if (load_r) rdata_nxt = bus.mem_rdata;
               mem_wr_nxt  = 1'b0;
               d_done_nxt  = own_d_r;
               if_done_nxt = ~own_d_r;
               err_nxt     = mis_r;
            end else begin
               cnt_nxt = cnt_r - 4'd1;
            end
         end
         DONE: begin
            if_done_nxt = 1'b0;
            d_done_nxt  = 1'b0;
            gnt_if_nxt  = 1'b0;
            gnt_d_nxt   = 1'b0;
            err_nxt     = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wr    = mem_wr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.gnt_if    = gnt_if_r;
   assign bus.gnt_d     = gnt_d_r;
   assign bus.if_done   = if_done_r;
   assign bus.d_done    = d_done_r;
   assign bus.rdata     = rdata_r;
   assign bus.err       = err_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table on the MEM_LAT=2 priority instance,
// plus hand sequences for tie ordering, reset mid-store and MEM_LAT=1/15 throughput.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if b0 ();
   mem_port_arbiter_if b1 ();
   mem_port_arbiter_if b2 ();
   mem_port_arbiter_if b3 ();

   mem_port_arbiter #(.MEM_LAT(2),  .DATA_PRIO(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
   mem_port_arbiter #(.MEM_LAT(2),  .DATA_PRIO(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
   mem_port_arbiter #(.MEM_LAT(1),  .DATA_PRIO(1)) u2 (.clk(clk), .rst(rst), .bus(b2));
   mem_port_arbiter #(.MEM_LAT(15), .DATA_PRIO(1)) u3 (.clk(clk), .rst(rst), .bus(b3));

   function automatic logic [31:0] pat(input logic [31:0] a);
      return 32'h1000_0000 + {2'b00, a[31:2]};
   endfunction

   // u0 memory: writable, one register stage so data is valid MEM_LAT=2 cycles after mem_addr
   logic [31:0] mem0 [0:63];
   logic [31:0] rd_pipe0;
   logic        mem_init;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem0[i] <= pat(32'(i) << 2);
      end else if (b0.mem_wr) begin
         mem0[b0.mem_addr[7:2]] <= b0.mem_wdata;
      end
      rd_pipe0 <= mem0[b0.mem_addr[7:2]];
   end
   assign b0.mem_rdata = rd_pipe0;
   assign b1.mem_rdata = pat(b1.mem_addr);
   assign b2.mem_rdata = pat(b2.mem_addr);
   assign b3.mem_rdata = pat(b3.mem_addr);

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input int id, input logic ifr, input logic dr);
      case (id)
         0: begin b0.if_req = ifr; b0.d_req = dr; end
         1: begin b1.if_req = ifr; b1.d_req = dr; end
         2: begin b2.if_req = ifr; b2.d_req = dr; end
         default: begin b3.if_req = ifr; b3.d_req = dr; end
      endcase
   endtask

   function automatic logic [1:0] dones(input int id);
      case (id)
         0: return {b0.if_done, b0.d_done};
         1: return {b1.if_done, b1.d_done};
         2: return {b2.if_done, b2.d_done};
         default: return {b3.if_done, b3.d_done};
      endcase
   endfunction

   function automatic logic [32:0] busy_rdata(input int id);
      case (id)
         0: return {b0.busy, b0.rdata};
         1: return {b1.busy, b1.rdata};
         2: return {b2.busy, b2.rdata};
         default: return {b3.busy, b3.rdata};
      endcase
   endfunction

   // flags = {mem_wr, gnt_if, gnt_d, if_done, d_done, err, busy}
   localparam logic [6:0] F_IDLE = 7'b0000000;
   localparam logic [6:0] F_IFA  = 7'b0100001;
   localparam logic [6:0] F_IFD  = 7'b0101001;
   localparam logic [6:0] F_DLA  = 7'b0010001;
   localparam logic [6:0] F_DST  = 7'b1010001;
   localparam logic [6:0] F_DD   = 7'b0010101;
   localparam logic [6:0] F_DERR = 7'b0010111;

   typedef struct {
      logic        ifr;
      logic [31:0] ifa;
      logic        dr;
      logic        dwe;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [6:0]  flg;
      logic        chk_a;
      logic [31:0] maddr;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic ifr, input logic [31:0] ifa, input logic dr,
                               input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                               input logic [6:0] flg, input logic chk_a,
                               input logic [31:0] maddr, input logic [31:0] rd);
      vec_t v;
      v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
      v.flg = flg; v.chk_a = chk_a; v.maddr = maddr; v.rd = rd;
      vecs.push_back(v);
   endfunction

   // Holds both requests, re-raising a port the cycle after its done; records grant order.
   task automatic run_alt(input int id, input logic [3:0] exp_order, input string nm);
      logic       ifr, dr;
      logic [1:0] dn;
      logic [3:0] order;
      int         got, cyc, both;
      drive(id, 1'b1, 1'b1);
      got = 0; cyc = 0; both = 0; order = '0;
      while (got < 4 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         dn  = dones(id);
         ifr = 1'b1;
         dr  = 1'b1;
         if (dn == 2'b11) both++;
         if (dn[1] && got < 4) begin order[got[1:0]] = 1'b0; got++; ifr = 1'b0; end
         if (dn[0] && got < 4) begin order[got[1:0]] = 1'b1; got++; dr  = 1'b0; end
         drive(id, ifr, dr);
      end
      drive(id, 1'b0, 1'b0);
      check({nm, " grants"}, 32'(got), 32'd4);
      check({nm, " order"}, {28'd0, order}, {28'd0, exp_order});
      check({nm, " dual done"}, 32'(both), 32'd0);
      repeat (2) @(negedge clk);
      check({nm, " idle after"}, 32'(busy_rdata(id) >> 32), 32'd0);
   endtask

   // IF request held continuously: first done after lat+1 cycles, then every lat+2.
   task automatic sweep(input int id, input int lat, input string nm);
      int         cyc, last, n, dd;
      logic [1:0] dn;
      drive(id, 1'b1, 1'b0);
      cyc = 0; last = 0; n = 0; dd = 0;
      while (n < 3 && cyc < 20 * (lat + 2)) begin
         @(negedge clk);
         cyc++;
         dn = dones(id);
         if (dn[0]) dd++;
         if (dn[1]) begin
            if (n == 0) check({nm, " first latency"}, 32'(cyc - last), 32'(lat + 1));
            else        check({nm, " done spacing"}, 32'(cyc - last), 32'(lat + 2));
            check({nm, " rdata"}, busy_rdata(id)[31:0], pat(32'h8));
            last = cyc;
            n++;
            if (n == 3) drive(id, 1'b0, 1'b0);
         end
      end
      drive(id, 1'b0, 1'b0);
      check({nm, " done count"}, 32'(n), 32'd3);
      check({nm, " no d_done"}, 32'(dd), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] seen;
      int         cyc;

      //   ifr ifa    dr dwe da     dwd           flags   chk maddr  rdata
      add(1, 32'h10, 0, 0, 32'h0,  32'h0,        F_IFA,  1, 32'h10, 32'h0);
      add(1, 32'h10, 0, 0, 32'h0,  32'h0,        F_IFA,  0, 32'h0,  32'h0);
      add(1, 32'h10, 0, 0, 32'h0,  32'h0,        F_IFD,  0, 32'h0,  32'h1000_0004);
      add(0, 32'h10, 0, 0, 32'h0,  32'h0,        F_IDLE, 0, 32'h0,  32'h1000_0004);
      add(0, 32'h0,  1, 1, 32'h40, 32'hDEADBEEF, F_DST,  1, 32'h40, 32'h1000_0004);
      add(0, 32'h0,  1, 1, 32'h40, 32'hDEADBEEF, F_DST,  0, 32'h0,  32'h1000_0004);
      add(0, 32'h0,  1, 1, 32'h40, 32'hDEADBEEF, F_DD,   0, 32'h0,  32'h1000_0004);
      add(0, 32'h0,  0, 1, 32'h40, 32'hDEADBEEF, F_IDLE, 0, 32'h0,  32'h1000_0004);
      add(1, 32'h40, 0, 0, 32'h0,  32'h0,        F_IFA,  1, 32'h40, 32'h1000_0004);
      add(1, 32'h40, 0, 0, 32'h0,  32'h0,        F_IFA,  0, 32'h0,  32'h1000_0004);
      add(1, 32'h40, 0, 0, 32'h0,  32'h0,        F_IFD,  0, 32'h0,  32'hDEADBEEF);
      add(0, 32'h40, 0, 0, 32'h0,  32'h0,        F_IDLE, 0, 32'h0,  32'hDEADBEEF);
      add(1, 32'h30, 1, 0, 32'h20, 32'h0,        F_DLA,  1, 32'h20, 32'hDEADBEEF);
      add(1, 32'h30, 1, 0, 32'h20, 32'h0,        F_DLA,  0, 32'h0,  32'hDEADBEEF);
      add(1, 32'h30, 1, 0, 32'h20, 32'h0,        F_DD,   0, 32'h0,  32'h1000_0008);
      add(1, 32'h30, 0, 0, 32'h20, 32'h0,        F_IDLE, 0, 32'h0,  32'h1000_0008);
      add(1, 32'h30, 0, 0, 32'h0,  32'h0,        F_IFA,  1, 32'h30, 32'h1000_0008);
      add(1, 32'h30, 0, 0, 32'h0,  32'h0,        F_IFA,  0, 32'h0,  32'h1000_0008);
      add(1, 32'h30, 0, 0, 32'h0,  32'h0,        F_IFD,  0, 32'h0,  32'h1000_000C);
      add(0, 32'h30, 0, 0, 32'h0,  32'h0,        F_IDLE, 0, 32'h0,  32'h1000_000C);
      add(0, 32'h0,  1, 0, 32'h42, 32'h0,        F_DLA,  1, 32'h42, 32'h1000_000C);
      add(0, 32'h0,  1, 0, 32'h42, 32'h0,        F_DLA,  0, 32'h0,  32'h1000_000C);
      add(0, 32'h0,  1, 0, 32'h42, 32'h0,        F_DERR, 0, 32'h0,  32'h1000_000C);
      add(0, 32'h0,  0, 0, 32'h42, 32'h0,        F_IDLE, 0, 32'h0,  32'h1000_000C);
      add(0, 32'h0,  1, 1, 32'h41, 32'h1234_5678, F_DLA, 1, 32'h41, 32'h1000_000C);
      add(0, 32'h0,  1, 1, 32'h41, 32'h1234_5678, F_DLA, 0, 32'h0,  32'h1000_000C);
      add(0, 32'h0,  1, 1, 32'h41, 32'h1234_5678, F_DERR, 0, 32'h0, 32'h1000_000C);
      add(0, 32'h0,  0, 1, 32'h41, 32'h1234_5678, F_IDLE, 0, 32'h0, 32'h1000_000C);

      b0.if_req = 0; b0.if_addr = '0; b0.d_req = 0; b0.d_we = 0; b0.d_addr = '0; b0.d_wdata = '0;
      b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
      b2.if_req = 0; b2.if_addr = '0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = '0; b2.d_wdata = '0;
      b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
      mem_init = 1'b1;
      rst      = 1'b1;
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      mem_init = 1'b0;
      @(negedge clk);

      check("reset flags", 32'({b0.mem_wr, b0.gnt_if, b0.gnt_d, b0.if_done, b0.d_done,
                                b0.err, b0.busy}), 32'(F_IDLE));
      check("reset mem_addr", b0.mem_addr, 32'h0);
      check("reset mem_wdata", b0.mem_wdata, 32'h0);
      check("reset rdata", b0.rdata, 32'h0);
      check("reset rr busy", 32'(b1.busy), 32'd0);

      foreach (vecs[i]) begin
         b0.if_req  = vecs[i].ifr;
         b0.if_addr = vecs[i].ifa;
         b0.d_req   = vecs[i].dr;
         b0.d_we    = vecs[i].dwe;
         b0.d_addr  = vecs[i].da;
         b0.d_wdata = vecs[i].dwd;
         @(negedge clk);
         check($sformatf("vec%0d flags", i),
               32'({b0.mem_wr, b0.gnt_if, b0.gnt_d, b0.if_done, b0.d_done, b0.err, b0.busy}),
               32'(vecs[i].flg));
         check($sformatf("vec%0d rdata", i), b0.rdata, vecs[i].rd);
         if (vecs[i].chk_a) check($sformatf("vec%0d mem_addr", i), b0.mem_addr, vecs[i].maddr);
      end

      // Tie ordering: fixed D priority starves IF; round-robin alternates starting with IF
      b0.if_addr = 32'h10; b0.d_addr = 32'h20; b0.d_we = 1'b0;
      b1.if_addr = 32'h10; b1.d_addr = 32'h20; b1.d_we = 1'b0;
      run_alt(0, 4'b1111, "prio tie");
      run_alt(1, 4'b1010, "rr tie");

      b2.if_addr = 32'h8;
      b3.if_addr = 32'h8;
      sweep(2, 1, "lat1");
      sweep(3, 15, "lat15");

      // Reset in the middle of a store
      b0.d_we = 1'b1; b0.d_addr = 32'h50; b0.d_wdata = 32'hCAFE_F00D;
      drive(0, 1'b0, 1'b1);
      @(negedge clk);
      check("pre-rst mem_wr", 32'(b0.mem_wr), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst mem_wr", 32'(b0.mem_wr), 32'd0);
      check("rst busy", 32'(b0.busy), 32'd0);
      check("rst gnt_d", 32'(b0.gnt_d), 32'd0);
      check("rst rdata", b0.rdata, 32'h0);
      drive(0, 1'b0, 1'b0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 2'b00;
      repeat (6) begin
         @(negedge clk);
         seen |= dones(0);
      end
      check("rst no done", 32'(seen), 32'd0);

      b0.if_addr = 32'h50;
      drive(0, 1'b1, 1'b0);
      cyc = 0;
      while (!b0.if_done && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check("post-rst latency", 32'(cyc), 32'd3);
      check("post-rst rdata", b0.rdata, pat(32'h50));
      drive(0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("post-rst idle", 32'(b0.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
